// File: rtl/cpri_rx_frame_tracker_if.sv
// ---------------------------------------------------------------------------
// cpri_rx_frame_tracker_if
//   Bundles the multi-lane CPRI rx bus and the framer outputs.
//   master : drives the lane inputs (rx side / bench), observes framer outputs
//   slave  : the framer itself
// Signals
//   i_lane_en  [LANES]        per-lane enable
//   i_rx_data  [LANES*DW]     lane words, lane k at [k*DW +: DW]
//   i_rx_vld   [LANES]        per-lane word valid
//   o_rx_data/o_rx_vld/o_fst_word/o_seq   registered word stream + index
//   o_hdr/o_agc0/o_agc1       last complete header/AGC set per lane
//   o_hdr_upd/o_frm_err/o_err_cnt         set-update, truncation pulse, counter
//   o_skew_err/o_tx_enable    global skew pulse and periodic tx strobe
// ---------------------------------------------------------------------------
interface cpri_rx_frame_tracker_if #(
  parameter int LANES     = 8,
  parameter int DW        = 64,
  parameter int FRAME_LEN = 96,
  parameter int ERRW      = 16
);
  localparam int SEQ_W = $clog2(FRAME_LEN);

  logic [LANES-1:0]       i_lane_en;
  logic [LANES*DW-1:0]    i_rx_data;
  logic [LANES-1:0]       i_rx_vld;
  logic [LANES*DW-1:0]    o_rx_data;
  logic [LANES-1:0]       o_rx_vld;
  logic [LANES-1:0]       o_fst_word;
  logic [LANES*SEQ_W-1:0] o_seq;
  logic [LANES*DW-1:0]    o_hdr;
  logic [LANES*DW-1:0]    o_agc0;
  logic [LANES*DW-1:0]    o_agc1;
  logic [LANES-1:0]       o_hdr_upd;
  logic [LANES-1:0]       o_frm_err;
  logic [LANES*ERRW-1:0]  o_err_cnt;
  logic                   o_skew_err;
  logic                   o_tx_enable;

  modport master (
    output i_lane_en, i_rx_data, i_rx_vld,
    input  o_rx_data, o_rx_vld, o_fst_word, o_seq, o_hdr, o_agc0, o_agc1,
           o_hdr_upd, o_frm_err, o_err_cnt, o_skew_err, o_tx_enable
  );

  modport slave (
    input  i_lane_en, i_rx_data, i_rx_vld,
    output o_rx_data, o_rx_vld, o_fst_word, o_seq, o_hdr, o_agc0, o_agc1,
           o_hdr_upd, o_frm_err, o_err_cnt, o_skew_err, o_tx_enable
  );
endinterface

// File: rtl/cpri_rx_frame_tracker.sv
// ---------------------------------------------------------------------------
// cpri_rx_frame_tracker
//   Multi-lane CPRI receive framer. Per lane it tracks the word index inside
//   each FRAME_LEN-word basic frame, marks the first word, captures the
//   header/AGC control words, and flags truncated frames. Globally it flags
//   inter-lane first-word skew and produces a periodic tx strobe after a
//   start-up delay.
// Ports
//   i_clk    : single clock
//   i_reset  : synchronous reset, active-high
//   bus      : cpri_rx_frame_tracker_if.slave (lane inputs and all outputs)
// All outputs are registered, one cycle after the input word they describe.
// ---------------------------------------------------------------------------
module cpri_rx_frame_tracker #(
  parameter int LANES        = 8,
  parameter int DW           = 64,
  parameter int FRAME_LEN    = 96,
  parameter int SEQ_W        = $clog2(FRAME_LEN),
  parameter int HDR_IDX      = 3,
  parameter int AGC0_IDX     = 5,
  parameter int AGC1_IDX     = 6,
  parameter int TX_START_DLY = 100,
  parameter int ERRW         = 16
) (
  input logic                   i_clk,
  input logic                   i_reset,
  cpri_rx_frame_tracker_if.slave bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } lane_state_e;

  localparam logic [SEQ_W-1:0] LAST_IDX = SEQ_W'(FRAME_LEN - 1);
  localparam logic [SEQ_W-1:0] HDR_I    = SEQ_W'(HDR_IDX);
  localparam logic [SEQ_W-1:0] AGC0_I   = SEQ_W'(AGC0_IDX);
  localparam logic [SEQ_W-1:0] AGC1_I   = SEQ_W'(AGC1_IDX);
  localparam int               SU_W     = $clog2(TX_START_DLY + 2);

  logic [LANES*DW-1:0]    data_v, hdr_v, agc0_v, agc1_v;
  logic [LANES*SEQ_W-1:0] seq_v;
  logic [LANES*ERRW-1:0]  err_cnt_v;
  logic [LANES-1:0]       vld_v, fst_v, upd_v, ferr_v;
  logic [LANES-1:0]       first_in, mid_in;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    lane_state_e      state_q, state_d;
    logic [SEQ_W-1:0] cnt_q, cnt_d, idx, seq_q;
    logic             accept, trunc;
    logic [DW-1:0]    din, data_q, hdr_q, agc0_q, agc1_q, shd_hdr, shd_agc0;
    logic             vld_q, fst_q, upd_q, ferr_q;
    logic [ERRW-1:0]  err_cnt_q;

    assign din    = bus.i_rx_data[k*DW +: DW];
    assign accept = bus.i_lane_en[k] & bus.i_rx_vld[k];
    // cnt is held at 0 in IDLE, so a word accepted from IDLE has index 0.
    assign idx    = (state_q == S_RUN) ? cnt_q : '0;

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      trunc   = 1'b0;
      if (!bus.i_lane_en[k]) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else if (bus.i_rx_vld[k]) begin
        state_d = S_RUN;
        cnt_d   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end else begin
        // A gap is a clean boundary only when the next expected index is 0.
        trunc   = (state_q == S_RUN) && (cnt_q != '0);
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        state_q   <= S_IDLE;
        cnt_q     <= '0;
        data_q    <= '0;
        vld_q     <= 1'b0;
        seq_q     <= '0;
        fst_q     <= 1'b0;
        upd_q     <= 1'b0;
        ferr_q    <= 1'b0;
        err_cnt_q <= '0;
        hdr_q     <= '0;
        agc0_q    <= '0;
        agc1_q    <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        data_q  <= bus.i_lane_en[k] ? din : '0;
        vld_q   <= accept;
        seq_q   <= accept ? idx : '0;
        fst_q   <= accept && (idx == '0);
        upd_q   <= accept && (idx == AGC1_I);
        ferr_q  <= trunc;
        if (trunc && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
        // Header and AGC0 precede AGC1 in every frame, so the shadows always
        // hold words of the same frame when AGC1 arrives.
        if (accept && (idx == AGC1_I)) begin
          hdr_q  <= shd_hdr;
          agc0_q <= shd_agc0;
          agc1_q <= din;
        end
      end
    end

    // NOTE: the shadow registers carry no reset; they are only published
    // after being loaded within the current frame, so their power-up value
    // never reaches an output.
    always_ff @(posedge i_clk) begin
      if (accept && (idx == HDR_I))  shd_hdr  <= din;
      if (accept && (idx == AGC0_I)) shd_agc0 <= din;
    end

    assign first_in[k] = accept && (idx == '0);
    assign mid_in[k]   = accept && (idx != '0);

    assign data_v[k*DW +: DW]        = data_q;
    assign hdr_v[k*DW +: DW]         = hdr_q;
    assign agc0_v[k*DW +: DW]        = agc0_q;
    assign agc1_v[k*DW +: DW]        = agc1_q;
    assign seq_v[k*SEQ_W +: SEQ_W]   = seq_q;
    assign err_cnt_v[k*ERRW +: ERRW] = err_cnt_q;
    assign vld_v[k]                  = vld_q;
    assign fst_v[k]                  = fst_q;
    assign upd_v[k]                  = upd_q;
    assign ferr_v[k]                 = ferr_q;
  end

  // Skew and tx strobe.
  logic             skew_q, tx_run_q, tx_en_q;
  logic [SU_W-1:0]  su_cnt_q;
  logic [SEQ_W-1:0] tx_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      skew_q   <= 1'b0;
      su_cnt_q <= '0;
      tx_run_q <= 1'b0;
      tx_cnt_q <= '0;
      tx_en_q  <= 1'b0;
    end else begin
      // A lane starting a frame while another is mid-frame means misalignment.
      skew_q <= (|first_in) && (|mid_in);
      if (su_cnt_q != SU_W'(TX_START_DLY)) su_cnt_q <= su_cnt_q + 1'b1;
      // tx_run lags saturation by one cycle, placing the first strobe at
      // TX_START_DLY+FRAME_LEN+1 cycles after reset release.
      tx_run_q <= (su_cnt_q == SU_W'(TX_START_DLY));
      if (tx_run_q) tx_cnt_q <= (tx_cnt_q == LAST_IDX) ? '0 : tx_cnt_q + 1'b1;
      tx_en_q <= tx_run_q && (tx_cnt_q == LAST_IDX);
    end
  end

  assign bus.o_rx_data   = data_v;
  assign bus.o_rx_vld    = vld_v;
  assign bus.o_fst_word  = fst_v;
  assign bus.o_seq       = seq_v;
  assign bus.o_hdr       = hdr_v;
  assign bus.o_agc0      = agc0_v;
  assign bus.o_agc1      = agc1_v;
  assign bus.o_hdr_upd   = upd_v;
  assign bus.o_frm_err   = ferr_v;
  assign bus.o_err_cnt   = err_cnt_v;
  assign bus.o_skew_err  = skew_q;
  assign bus.o_tx_enable = tx_en_q;

endmodule

// File: doc/cpri_rx_frame_tracker.md
Name: cpri_rx_frame_tracker

Overview:
- Synthesizable multi-lane CPRI receive-side framer, sitting between the per-lane CPRI rx interfaces and the pusch_dr_top ingress.
- Per lane: tracks the word index inside each FRAME_LEN-word basic frame, generates the first-word marker, and captures the header and AGC control words.
- Flags truncated frames and inter-lane skew.
- Also generates the periodic iq_tx_enable strobe after a programmable start-up delay, replacing the open-loop counters currently kept in benches.

Parameters:
- LANES, 8, number of CPRI lanes
- DW, 64, data word width per lane
- FRAME_LEN, 96, words per frame (>=8)
- SEQ_W, $clog2(FRAME_LEN), word-index width (derived)
- HDR_IDX, 3, index of the header word
- AGC0_IDX, 5, index of the first AGC word
- AGC1_IDX, 6, index of the second AGC word (HDR_IDX < AGC0_IDX < AGC1_IDX < FRAME_LEN)
- TX_START_DLY, 100, cycles after reset release before the tx counter runs
- ERRW, 16, error counter width

Ports:
- i_clk  in  1  single clock
- i_reset  in  1  synchronous reset, active-high
- i_lane_en  in  LANES  per-lane enable; a disabled lane is held in IDLE and its outputs are 0
- i_rx_data  in  LANES*DW  lane rx words, lane k at [k*DW +: DW]
- i_rx_vld  in  LANES  per-lane word valid
- o_rx_data  out  LANES*DW  rx data, registered (1-cycle delay)
- o_rx_vld  out  LANES  registered valid
- o_fst_word  out  LANES  high with the index-0 word on o_rx_data
- o_seq  out  LANES*SEQ_W  index of the word on o_rx_data
- o_hdr  out  LANES*DW  last captured header word
- o_agc0  out  LANES*DW  last captured AGC0 word
- o_agc1  out  LANES*DW  last captured AGC1 word
- o_hdr_upd  out  LANES  1-cycle pulse when a complete hdr/agc0/agc1 set of one frame is visible
- o_frm_err  out  LANES  1-cycle truncated-frame pulse
- o_err_cnt  out  LANES*ERRW  saturating truncated-frame counter
- o_skew_err  out  1  1-cycle inter-lane first-word mismatch pulse
- o_tx_enable  out  1  periodic tx strobe

Behaviour:
- Reset: all outputs 0, all lanes IDLE, counters 0, tx start-up counter 0. Reset mid-frame discards the partial frame and does not count an error.
- Per-lane FSM, IDLE/RUN, with internal counter cnt (next expected index):
  - IDLE, vld=1: word index 0. Go to RUN, cnt<=1 (cnt<=0 if FRAME_LEN==1 is not allowed).
  - IDLE, vld=0: stay; cnt=0.
  - RUN, vld=1: word index = cnt. cnt<=cnt+1, wrapping to 0 after FRAME_LEN-1; stay in RUN.
  - RUN, vld=0, cnt==0: clean frame boundary. Go to IDLE, no error.
  - RUN, vld=0, cnt!=0: truncated frame. o_frm_err pulses the next cycle, o_err_cnt increments (saturates at all-ones), go to IDLE, cnt<=0, and discard the partially captured set (no o_hdr_upd).
  - i_lane_en=0: forces IDLE next cycle without an error; err_cnt is held.
- Output timing, all registered with 1-cycle latency: o_rx_data/o_rx_vld/o_seq/o_fst_word. o_fst_word = vld & index==0. o_seq is 0 when vld=0.
- Capture: a word at HDR_IDX/AGC0_IDX/AGC1_IDX is loaded into shadow registers. On accepting the AGC1_IDX word, all three are copied to o_hdr/o_agc0/o_agc1 in the same cycle that o_hdr_upd pulses (1 cycle after the AGC1 input word). Output registers change only on o_hdr_upd.
- Skew: in any cycle where at least one enabled lane's input is index 0 and at least one other enabled lane in RUN has vld=1 at a non-zero index, o_skew_err pulses the next cycle. Lanes in IDLE or disabled are ignored.
- Tx strobe:
  - The start-up counter counts from reset release and saturates at TX_START_DLY.
  - Once saturated, tx_cnt runs 0..FRAME_LEN-1, free-running and wrapping.
  - o_tx_enable is registered as tx_cnt==FRAME_LEN-1. It is first high TX_START_DLY+FRAME_LEN+1 cycles after reset deassertion, then every FRAME_LEN cycles.
- Simultaneous events:
  - Truncation in one lane while another starts a frame: both are handled independently.
  - Reset wins over everything.

Test Plan:
- Reset deasserted, lane0 vld high for 96 contiguous cycles with data=index → o_fst_word at the first output cycle, o_seq 0..95; o_hdr=3, o_agc0=5, o_agc1=6; o_hdr_upd one cycle after input index 6; no errors.
- Lane0 vld for 192 contiguous cycles → two o_fst_word pulses 96 cycles apart, o_seq wraps 95→0, o_hdr_upd twice.
- Lane2 vld drops after 40 words → o_frm_err pulse, o_err_cnt[2]=1, o_hdr/agc unchanged from the previous frame, next vld restarts at seq 0.
- All 8 lanes start together, except lane 5 started 1 cycle earlier → o_skew_err pulses once; with all lanes aligned, o_skew_err stays 0.
- Reset released, no rx traffic → o_tx_enable first high at cycle 197, then at 293, 389; reset asserted at cycle 250 → no pulse until 197 cycles after the new release.
- i_lane_en[1] cleared mid-frame → lane 1 outputs 0, o_err_cnt[1] unchanged; re-enabled with vld → restarts at seq 0.
